// File: rtl/card_dealer_if.sv
// Bus between the card_dealer and its controller: requests and random word in,
// dealt card, status and FSM state (state_dbg) out.
//
// Handshake: deal_req and shuffle_req are single-cycle strobes, taken only
// while busy=0 and dropped otherwise. card_valid and deal_err are single-cycle
// pulses with no back-pressure. card_id/rank/suit are valid while card_valid=1.
interface card_dealer_if;
    logic [31:0] randnum;
    logic        deal_req;
    logic        shuffle_req;
    logic        card_valid;
    logic [5:0]  card_id;
    logic [3:0]  rank;
    logic [1:0]  suit;
    logic        deal_err;
    logic        busy;
    logic [5:0]  cards_left;
    logic        deck_empty;
    logic [1:0]  state_dbg;

    modport master (
        output randnum, deal_req, shuffle_req,
        input  card_valid, card_id, rank, suit, deal_err, busy, cards_left,
               deck_empty, state_dbg
    );

    modport slave (
        input  randnum, deal_req, shuffle_req,
        output card_valid, card_id, rank, suit, deal_err, busy, cards_left,
               deck_empty, state_dbg
    );
endinterface

// File: rtl/card_dealer.sv
// Deals unique cards from a 52-card deck by probing a used-card bitmap from a random start.
// Optional macro CARD_DEALER_AUTOSHUFFLE_EN: a deal on an empty deck reshuffles instead of erroring.
module card_dealer #(
    parameter int RAND_LSB = 0
) (
    input  logic          clk,
    input  logic          rst,
    card_dealer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t      state;
    logic [51:0] used;
    logic [5:0]  cand;
    logic [5:0]  cards_left;
    logic [5:0]  slice;
    logic [5:0]  load_cand;
    logic        card_valid;
    logic        deal_err;
    logic [5:0]  card_id;
    logic [3:0]  rank;
    logic [1:0]  suit;

    // Fold 52..63 back onto 0..11 so every slice maps to a real card.
    assign slice     = bus.randnum[RAND_LSB +: 6];
    assign load_cand = (slice >= 6'd52) ? (slice - 6'd52) : slice;

    function automatic logic [5:0] suit_rank(input logic [5:0] id);
        logic [1:0] s;
        logic [5:0] rem;
        if (id >= 6'd39) begin
            s = 2'd3; rem = id - 6'd39;
        end else if (id >= 6'd26) begin
            s = 2'd2; rem = id - 6'd26;
        end else if (id >= 6'd13) begin
            s = 2'd1; rem = id - 6'd13;
        end else begin
            s = 2'd0; rem = id;
        end
        return {s, rem[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            used       <= '0;
            cards_left <= 6'd52;
            cand       <= '0;
            card_id    <= '0;
            rank       <= 4'd1;
            suit       <= '0;
            card_valid <= 1'b0;
            deal_err   <= 1'b0;
        end else begin
            card_valid <= 1'b0;
            deal_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.shuffle_req) begin
                        used       <= '0;
                        cards_left <= 6'd52;
                    end else if (bus.deal_req) begin
                        if (cards_left == 6'd0) begin
`ifdef CARD_DEALER_AUTOSHUFFLE_EN
                            used       <= '0;
                            cards_left <= 6'd52;
                            cand       <= load_cand;
                            state      <= PROBE;
`else
                            deal_err   <= 1'b1;
`endif
                        end else begin
                            cand  <= load_cand;
                            state <= PROBE;
                        end
                    end
                end
                PROBE: begin
                    // Terminates: PROBE is only entered with at least one free card.
                    if (!used[cand]) begin
                        used[cand]     <= 1'b1;
                        cards_left     <= cards_left - 6'd1;
                        card_id        <= cand;
                        {suit, rank}   <= suit_rank(cand);
                        state          <= EMIT;
                    end else begin
                        cand <= (cand == 6'd51) ? 6'd0 : (cand + 6'd1);
                    end
                end
                EMIT: begin
                    card_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.card_valid = card_valid;
    assign bus.deal_err   = deal_err;
    assign bus.card_id    = card_id;
    assign bus.rank       = rank;
    assign bus.suit       = suit;
    assign bus.cards_left = cards_left;
    assign bus.deck_empty = (cards_left == 6'd0);
    assign bus.busy       = (state != IDLE);
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a reference deck model feeds an expected-card queue.
module tb_card_dealer;
    localparam int RAND_LSB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    card_dealer_if dif();

    card_dealer #(.RAND_LSB(RAND_LSB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_q[$];
    logic [51:0] m_used;
    int          m_left;
    int          last_id;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_for(input logic [5:0] s);
        logic [31:0] w;
        w = $urandom;
        w[RAND_LSB +: 6] = s;
        return w;
    endfunction

    // Deal one card through the scoreboard; latency and state are checked inline.
    task automatic do_deal(input logic [5:0] s);
        int cand, extra, n;
        logic [11:0] exp, got;
        cand  = (s >= 6'd52) ? int'(s) - 52 : int'(s);
        extra = 0;
        while (m_used[cand] && extra < 52) begin
            cand = (cand == 51) ? 0 : cand + 1;
            extra++;
        end
        m_used[cand] = 1'b1;
        m_left--;
        exp_q.push_back({6'(cand), 4'(cand % 13 + 1), 2'(cand / 13)});

        @(negedge clk);
        dif.randnum  = word_for(s);
        dif.deal_req = 1'b1;
        @(negedge clk);
        dif.deal_req = 1'b0;
        dif.randnum  = $urandom;
        n = 0;
        while (!dif.card_valid && n < 100) begin
            @(negedge clk);
            n++;
            if (dif.deal_err) begin
                n_checks++; n_fail++;
                $display("FAIL deal_err_during_deal: deal_err=1 required 0 (slice %0d)", s);
            end
        end
        n_checks++;
        if (!dif.card_valid) begin
            n_fail++;
            $display("FAIL deal_timeout: no card_valid within 100 cycles (slice %0d)", s);
            void'(exp_q.pop_front());
            return;
        end
        exp = exp_q.pop_front();
        got = {dif.card_id, dif.rank, dif.suit};
        last_id = int'(dif.card_id);
        if (got !== exp) begin
            n_fail++;
            $display("FAIL card: got id=%0d rank=%0d suit=%0d, expected id=%0d rank=%0d suit=%0d",
                     got[11:6], got[5:2], got[1:0], exp[11:6], exp[5:2], exp[1:0]);
        end
        n_checks++;
        if (n !== 2 + extra) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, expected %0d (slice %0d)", n, 2 + extra, s);
        end
        n_checks++;
        if (dif.cards_left !== 6'(m_left) || dif.deal_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cards_left_after_deal: got %0d deal_err=%0b, expected %0d deal_err=0",
                     dif.cards_left, dif.deal_err, m_left);
        end
        @(negedge clk);
        n_checks++;
        if (dif.card_valid !== 1'b0 || dif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_pulse_width: card_valid=%0b busy=%0b, expected 0 0",
                     dif.card_valid, dif.busy);
        end
    endtask

    task automatic do_shuffle();
        @(negedge clk);
        dif.shuffle_req = 1'b1;
        @(negedge clk);
        dif.shuffle_req = 1'b0;
        m_used = '0;
        m_left = 52;
        n_checks++;
        if (dif.cards_left !== 6'd52 || dif.deck_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL shuffle: cards_left=%0d deck_empty=%0b, expected 52 0",
                     dif.cards_left, dif.deck_empty);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dif.deal_req    = 1'b0;
        dif.shuffle_req = 1'b0;
        dif.randnum     = $urandom;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dif.card_valid !== 1'b0 || dif.deal_err !== 1'b0 || dif.busy !== 1'b0 ||
            dif.deck_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%0b err=%0b busy=%0b empty=%0b, expected all 0",
                     dif.card_valid, dif.deal_err, dif.busy, dif.deck_empty);
        end
        n_checks++;
        if (dif.card_id !== 6'd0 || dif.rank !== 4'd1 || dif.suit !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_card: id=%0d rank=%0d suit=%0d, expected 0 1 0",
                     dif.card_id, dif.rank, dif.suit);
        end
        n_checks++;
        if (dif.cards_left !== 6'd52 || dif.state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: cards_left=%0d state=%0d, expected 52 0",
                     dif.cards_left, dif.state_dbg);
        end
        rst = 1'b0;
        m_used = '0;
        m_left = 52;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_deal(6'd5);
    endtask

    task automatic test_probe();
        do_deal(6'd60);
        do_deal(6'd8);
    endtask

    task automatic test_wrap();
        do_shuffle();
        do_deal(6'd51);
        do_deal(6'd51);
        do_deal(6'd63);
    endtask

    task automatic test_full_deck();
        logic [51:0] seen;
        int n;
        do_shuffle();
        seen = '0;
        for (int i = 0; i < 52; i++) begin
            do_deal(6'($urandom_range(0, 63)));
            n_checks++;
            if (seen[last_id]) begin
                n_fail++;
                $display("FAIL unique: card %0d dealt twice", last_id);
            end
            seen[last_id] = 1'b1;
        end
        n_checks++;
        if (dif.deck_empty !== 1'b1 || dif.cards_left !== 6'd0) begin
            n_fail++;
            $display("FAIL deck_empty: empty=%0b cards_left=%0d, expected 1 0",
                     dif.deck_empty, dif.cards_left);
        end
`ifdef CARD_DEALER_AUTOSHUFFLE_EN
        m_used = '0;
        m_left = 52;
        do_deal(6'd17);
`else
        @(negedge clk);
        dif.randnum  = word_for(6'd17);
        dif.deal_req = 1'b1;
        @(negedge clk);
        dif.deal_req = 1'b0;
        n_checks++;
        if (dif.deal_err !== 1'b1 || dif.card_valid !== 1'b0 || dif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL deal_err_pulse: err=%0b valid=%0b busy=%0b, expected 1 0 0",
                     dif.deal_err, dif.card_valid, dif.busy);
        end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dif.deal_err || dif.card_valid) n++;
        end
        n_checks++;
        if (n !== 0 || dif.cards_left !== 6'd0) begin
            n_fail++;
            $display("FAIL empty_after_err: %0d stray pulses, cards_left=%0d, expected 0 0",
                     n, dif.cards_left);
        end
`endif
    endtask

    task automatic test_shuffle_priority();
        int n;
        do_shuffle();
        do_deal(6'd1);
        do_deal(6'd2);
        do_deal(6'd3);
        @(negedge clk);
        dif.randnum     = word_for(6'd4);
        dif.deal_req    = 1'b1;
        dif.shuffle_req = 1'b1;
        @(negedge clk);
        dif.deal_req    = 1'b0;
        dif.shuffle_req = 1'b0;
        m_used = '0;
        m_left = 52;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (dif.card_valid || dif.deal_err || dif.busy) n++;
            @(negedge clk);
        end
        n_checks++;
        if (n !== 0 || dif.cards_left !== 6'd52) begin
            n_fail++;
            $display("FAIL shuffle_priority: %0d activity cycles, cards_left=%0d, expected 0 52",
                     n, dif.cards_left);
        end
    endtask

    task automatic test_reset_mid_probe();
        int n;
        do_shuffle();
        do_deal(6'd20);
        do_deal(6'd21);
        do_deal(6'd22);
        @(negedge clk);
        dif.randnum  = word_for(6'd20);
        dif.deal_req = 1'b1;
        @(negedge clk);
        dif.deal_req = 1'b0;
        n_checks++;
        if (dif.busy !== 1'b1 || dif.state_dbg !== 2'd1) begin
            n_fail++;
            $display("FAIL probe_entered: busy=%0b state=%0d, expected 1 1", dif.busy, dif.state_dbg);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_used = '0;
        m_left = 52;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (dif.card_valid || dif.busy) n++;
            @(negedge clk);
        end
        n_checks++;
        if (n !== 0 || dif.cards_left !== 6'd52) begin
            n_fail++;
            $display("FAIL reset_abort: %0d activity cycles, cards_left=%0d, expected 0 52",
                     n, dif.cards_left);
        end
        do_deal(6'd20);
    endtask

    task automatic test_busy_ignore();
        int n;
        do_shuffle();
        @(negedge clk);
        dif.randnum  = word_for(6'd30);
        dif.deal_req = 1'b1;
        @(negedge clk);
        dif.randnum  = word_for(6'd40);
        dif.shuffle_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dif.deal_req    = 1'b0;
        dif.shuffle_req = 1'b0;
        n_checks++;
        if (dif.card_valid !== 1'b1 || dif.card_id !== 6'd30 || dif.rank !== 4'd5 ||
            dif.suit !== 2'd2) begin
            n_fail++;
            $display("FAIL busy_deal: valid=%0b id=%0d rank=%0d suit=%0d, expected 1 30 5 2",
                     dif.card_valid, dif.card_id, dif.rank, dif.suit);
        end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dif.card_valid || dif.busy) n++;
        end
        n_checks++;
        if (n !== 0 || dif.cards_left !== 6'd51) begin
            n_fail++;
            $display("FAIL busy_ignore: %0d extra activity cycles, cards_left=%0d, expected 0 51",
                     n, dif.cards_left);
        end
        m_used[30] = 1'b1;
        m_left     = 51;
    endtask

    initial begin
        dif.randnum     = '0;
        dif.deal_req    = 1'b0;
        dif.shuffle_req = 1'b0;
        test_reset();
        test_basic();
        test_probe();
        test_wrap();
        test_busy_ignore();
        test_full_deck();
        test_shuffle_priority();
        test_reset_mid_probe();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected cards left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 Parameter RAND_LSB, default 0: lowest bit of the 6-bit slice taken from randnum; the slice is randnum[RAND_LSB+5:RAND_LSB]; legal range 0..26.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 randnum  in  32  free-running pseudo-random word from the upstream LFSR; it advances every cycle.
REQ-005 deal_req  in  1  single-cycle request to deal one card; sampled only in IDLE.
REQ-006 shuffle_req  in  1  single-cycle request to return all 52 cards to the deck; sampled only in IDLE.
REQ-007 card_valid  out  1  one-cycle pulse; card_id, rank and suit are valid in the same cycle.
REQ-008 card_id  out  6  dealt card index, 0..51.
REQ-009 rank  out  4  card rank: 1=A, 2..10, 11=J, 12=Q, 13=K.
REQ-010 suit  out  2  card suit, 0..3.
REQ-011 deal_err  out  1  one-cycle pulse when deal_req is accepted with deck_empty=1.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 cards_left  out  6  number of undealt cards, 0..52.
REQ-014 deck_empty  out  1  high when cards_left==0.

Function
REQ-015 FSM states: IDLE, PROBE, EMIT.
- IDLE: shuffle_req -> used bitmap cleared and cards_left=52 on the next edge; state stays IDLE.
- IDLE: otherwise deal_req with deck_empty=1 -> deal_err pulses next cycle; state stays IDLE.
- IDLE: otherwise deal_req -> cand loaded, then PROBE.
REQ-016 shuffle_req has priority over a simultaneous deal_req; that deal_req is dropped.
REQ-017 Candidate load: r = randnum slice; cand = r-52 when r>=52, otherwise cand = r.
REQ-018 PROBE, each cycle:
- used[cand]==0 -> set used[cand], decrement cards_left, register card_id=cand, go to EMIT.
- used[cand]==1 -> cand = (cand==51) ? 0 : cand+1; stay in PROBE.
REQ-019 EMIT: card_valid=1 for exactly one cycle, then IDLE.
REQ-020 Latency:
- deal_req accepted at edge N -> card_valid high during the cycle after edge N+2 (best case).
- Worst case is 51 extra PROBE cycles; termination is guaranteed because the deck is non-empty.
REQ-021 rank = (card_id mod 13)+1 and suit = card_id div 13, both registered alongside card_id; they hold their value until the next deal.
REQ-022 deal_req and shuffle_req are ignored while busy=1; no queuing.
REQ-023 cards_left never underflows below 0 and never exceeds 52.
REQ-024 card_valid and deal_err are never high in the same cycle.

Reset
REQ-025 While rst is high, the following hold:
- state=IDLE, used bitmap all zero, cards_left=52.
- card_valid=0, deal_err=0, busy=0, deck_empty=0.
- card_id=0, rank=1, suit=0.
REQ-026 Reset asserted in PROBE or EMIT aborts the deal.
- No card_valid is produced.
- No used bit is set by the aborted deal.

Configuration
REQ-027 Macro CARD_DEALER_AUTOSHUFFLE_EN.
- Defined: deal_req in IDLE with deck_empty=1 clears the bitmap, sets cards_left=52 and proceeds to PROBE as a normal deal; deal_err is tied to 0.
- Undefined: behaviour follows REQ-015 (deal_err pulse, no deal).

Verification
REQ-028 Reset, then deal_req with randnum slice=5 -> card_valid 2 cycles later with card_id=5, rank=6, suit=0; cards_left=51.
REQ-029 Slice=60 -> card_id=8, rank=9; a following deal with slice=8 -> probe to card_id=9 with 1 extra cycle, rank=10, suit=0.
REQ-030 Mark card 51 used, then deal with cand=51 -> wrap to card_id=0, rank=1, suit=0.
REQ-031 52 deals -> all card_id unique, deck_empty=1; a 53rd deal_req gives deal_err pulse (macro undefined) or card_valid with cards_left=51 (macro defined).
REQ-032 deal_req and shuffle_req in the same cycle after 3 deals -> no card_valid, cards_left=52; rst pulse mid-PROBE -> no card_valid, cards_left=52.
